// File: rtl/ramb_arb_pkg.sv
// Shared definitions for the RAMB4 port-B arbiter: FSM encoding and
// default port-B geometry of a RAMB4_S4 (1024 x 4).
package ramb_arb_pkg;

    typedef enum logic {
        ARB   = 1'b0,
        CLEAR = 1'b1
    } arb_state_t;

    localparam int RAMB4_S4_ADDR_W = 10;
    localparam int RAMB4_S4_DATA_W = 4;

endpackage

// File: rtl/ramb_rr_arb2.sv
// Two-way round-robin grant logic. The pointer remembers the last winner
// and only moves when a grant is actually issued.
module ramb_rr_arb2 (
    input  logic CLK,
    input  logic RST,
    input  logic valid0,
    input  logic valid1,
    input  logic enable,
    output logic gnt0,
    output logic gnt1
);

    // 1 = requester 1 won last, so requester 0 takes the first tie.
    logic last1;

    assign gnt0 = enable & valid0 & (~valid1 | last1);
    assign gnt1 = enable & valid1 & (~valid0 | ~last1);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            last1 <= 1'b1;
        else if (gnt0)
            last1 <= 1'b0;
        else if (gnt1)
            last1 <= 1'b1;
    end

endmodule

// File: rtl/ramb4_portb_arbiter.sv
// Round-robin sharing of RAMB4 port B between two clients, with a full-RAM
// clear sweep. Define RAMB_ARB_STATS_EN to add saturating grant counters.
module ramb4_portb_arbiter
    import ramb_arb_pkg::*;
#(
    parameter int                ADDR_W    = RAMB4_S4_ADDR_W,
    parameter int                DATA_W    = RAMB4_S4_DATA_W,
    parameter logic [DATA_W-1:0] CLR_VALUE = '0
`ifdef RAMB_ARB_STATS_EN
    , parameter int              CNT_W     = 16
`endif
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              REQ0_VALID,
    output logic              REQ0_READY,
    input  logic              REQ0_WE,
    input  logic [ADDR_W-1:0] REQ0_ADDR,
    input  logic [DATA_W-1:0] REQ0_WDATA,
    input  logic              REQ1_VALID,
    output logic              REQ1_READY,
    input  logic              REQ1_WE,
    input  logic [ADDR_W-1:0] REQ1_ADDR,
    input  logic [DATA_W-1:0] REQ1_WDATA,
    output logic              RVALID,
    output logic              RID,
    output logic [DATA_W-1:0] RDATA,
    input  logic              CLR_START,
    output logic              CLR_BUSY,
    output logic              CLR_DONE,
    output logic              RAM_EN,
    output logic              RAM_WE,
    output logic              RAM_RST,
    output logic [ADDR_W-1:0] RAM_ADDR,
    output logic [DATA_W-1:0] RAM_DI,
    input  logic [DATA_W-1:0] RAM_DO
`ifdef RAMB_ARB_STATS_EN
    , output logic [CNT_W-1:0] GNT_CNT0
    , output logic [CNT_W-1:0] GNT_CNT1
`endif
);

    arb_state_t        state, state_nxt;
    logic [ADDR_W-1:0] clr_cnt, clr_cnt_nxt;
    logic              arb_en, gnt0, gnt1, clr_last;

    assign arb_en   = ~RST & (state == ARB) & ~CLR_START;
    assign clr_last = (state == CLEAR) && (clr_cnt == '1);

    ramb_rr_arb2 u_rr (
        .CLK    (CLK),
        .RST    (RST),
        .valid0 (REQ0_VALID),
        .valid1 (REQ1_VALID),
        .enable (arb_en),
        .gnt0   (gnt0),
        .gnt1   (gnt1)
    );

    assign REQ0_READY = gnt0;
    assign REQ1_READY = gnt1;
    assign RDATA      = RAM_DO;
    assign RAM_RST    = 1'b0;
    assign CLR_BUSY   = (state == CLEAR);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state   <= ARB;
            clr_cnt <= '0;
        end else begin
            state   <= state_nxt;
            clr_cnt <= clr_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        clr_cnt_nxt = clr_cnt;
        RAM_EN      = 1'b0;
        RAM_WE      = 1'b0;
        RAM_ADDR    = '0;
        RAM_DI      = '0;
        case (state)
            ARB: begin
                if (CLR_START && !RST) begin
                    state_nxt   = CLEAR;
                    clr_cnt_nxt = '0;
                end else if (gnt0) begin
                    RAM_EN   = 1'b1;
                    RAM_WE   = REQ0_WE;
                    RAM_ADDR = REQ0_ADDR;
                    RAM_DI   = REQ0_WDATA;
                end else if (gnt1) begin
                    RAM_EN   = 1'b1;
                    RAM_WE   = REQ1_WE;
                    RAM_ADDR = REQ1_ADDR;
                    RAM_DI   = REQ1_WDATA;
                end
            end
            CLEAR: begin
                RAM_EN      = 1'b1;
                RAM_WE      = 1'b1;
                RAM_ADDR    = clr_cnt;
                RAM_DI      = CLR_VALUE;
                clr_cnt_nxt = clr_cnt + 1'b1;
                // Leaving CLEAR on the top address is what stops a second pass.
                if (clr_cnt == '1)
                    state_nxt = ARB;
            end
            default: state_nxt = ARB;
        endcase
    end

    // The RAM registers DOB on the grant edge, so the tag lines up one cycle later.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            RVALID   <= 1'b0;
            RID      <= 1'b0;
            CLR_DONE <= 1'b0;
        end else begin
            RVALID   <= (gnt0 & ~REQ0_WE) | (gnt1 & ~REQ1_WE);
            RID      <= gnt1;
            CLR_DONE <= clr_last;
        end
    end

`ifdef RAMB_ARB_STATS_EN
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            GNT_CNT0 <= '0;
            GNT_CNT1 <= '0;
        end else begin
            if (gnt0 && GNT_CNT0 != '1)
                GNT_CNT0 <= GNT_CNT0 + 1'b1;
            if (gnt1 && GNT_CNT1 != '1)
                GNT_CNT1 <= GNT_CNT1 + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_ramb4_portb_arbiter.sv
// Bench for ramb4_portb_arbiter: behavioural RAM plus a transaction-level
// model of arbitration, read return and the clear sweep.
module tb_ramb4_portb_arbiter;

    localparam int AW    = 10;
    localparam int DW    = 4;
    localparam int DEPTH = 1 << AW;
    localparam logic [DW-1:0] CLR_VAL = 4'h3;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          REQ0_VALID = 0, REQ0_WE = 0, REQ1_VALID = 0, REQ1_WE = 0;
    logic [AW-1:0] REQ0_ADDR = '0, REQ1_ADDR = '0;
    logic [DW-1:0] REQ0_WDATA = '0, REQ1_WDATA = '0;
    logic          REQ0_READY, REQ1_READY, RVALID, RID;
    logic [DW-1:0] RDATA;
    logic          CLR_START = 0, CLR_BUSY, CLR_DONE;
    logic          RAM_EN, RAM_WE, RAM_RST;
    logic [AW-1:0] RAM_ADDR;
    logic [DW-1:0] RAM_DI;
    logic [DW-1:0] RAM_DO = '0;
`ifdef RAMB_ARB_STATS_EN
    logic [15:0]   GNT_CNT0, GNT_CNT1;
`endif

    ramb4_portb_arbiter #(.ADDR_W(AW), .DATA_W(DW), .CLR_VALUE(CLR_VAL)) dut (
        .CLK(CLK), .RST(RST),
        .REQ0_VALID(REQ0_VALID), .REQ0_READY(REQ0_READY), .REQ0_WE(REQ0_WE),
        .REQ0_ADDR(REQ0_ADDR), .REQ0_WDATA(REQ0_WDATA),
        .REQ1_VALID(REQ1_VALID), .REQ1_READY(REQ1_READY), .REQ1_WE(REQ1_WE),
        .REQ1_ADDR(REQ1_ADDR), .REQ1_WDATA(REQ1_WDATA),
        .RVALID(RVALID), .RID(RID), .RDATA(RDATA),
        .CLR_START(CLR_START), .CLR_BUSY(CLR_BUSY), .CLR_DONE(CLR_DONE),
        .RAM_EN(RAM_EN), .RAM_WE(RAM_WE), .RAM_RST(RAM_RST),
        .RAM_ADDR(RAM_ADDR), .RAM_DI(RAM_DI), .RAM_DO(RAM_DO)
`ifdef RAMB_ARB_STATS_EN
        , .GNT_CNT0(GNT_CNT0), .GNT_CNT1(GNT_CNT1)
`endif
    );

    always #5 CLK = ~CLK;

    // RAMB4 port B, write-first, synchronous output register
    logic [DW-1:0] ram [DEPTH];
    always @(posedge CLK) begin
        if (RAM_EN) begin
            if (RAM_WE) begin
                ram[RAM_ADDR] <= RAM_DI;
                RAM_DO        <= RAM_DI;
            end else begin
                RAM_DO <= ram[RAM_ADDR];
            end
        end
    end

    int checks = 0;
    int errors = 0;

    // pending requests held by each client until accepted
    bit            r0v, r0we, r1v, r1we;
    logic [AW-1:0] r0a, r1a;
    logic [DW-1:0] r0d, r1d;

    // reference model state
    logic [DW-1:0] m_mem [DEPTH];
    int            m_last = 1;
    bit            m_busy = 0;
    int            m_ci   = 0;
    int            g0 = 0, g1 = 0;
    int            busy_cycles = 0, done_cnt = 0;
    int            grants[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        RST = 1'b1;
        REQ0_VALID = 1'b1;
        REQ1_VALID = 1'b1;
        CLR_START  = 1'b0;
        #2;
        chk("rst_ready0", REQ0_READY, 0);
        chk("rst_ready1", REQ1_READY, 0);
        chk("rst_ram_en", RAM_EN, 0);
        chk("rst_busy", CLR_BUSY, 0);
        @(posedge CLK); #1;
        chk("rst_rvalid", RVALID, 0);
        chk("rst_rid", RID, 0);
        chk("rst_done", CLR_DONE, 0);
`ifdef RAMB_ARB_STATS_EN
        chk("rst_cnt0", GNT_CNT0, 0);
        chk("rst_cnt1", GNT_CNT1, 0);
`endif
        RST = 1'b0;
        r0v = 0; r1v = 0;
        m_last = 1; m_busy = 0; m_ci = 0; g0 = 0; g1 = 0;
    endtask

    // One clock: drive pending requests, check grants against the model,
    // then check the registered read return after the edge.
    task automatic cycle(input bit cs);
        bit e0, e1, exp_rv, exp_rid, exp_done;
        logic [DW-1:0] exp_rd;
        REQ0_VALID = r0v; REQ0_WE = r0we; REQ0_ADDR = r0a; REQ0_WDATA = r0d;
        REQ1_VALID = r1v; REQ1_WE = r1we; REQ1_ADDR = r1a; REQ1_WDATA = r1d;
        CLR_START  = cs;
        #2;
        e0 = 0; e1 = 0;
        if (!m_busy && !cs) begin
            if (r0v && r1v) begin
                if (m_last == 1) e0 = 1; else e1 = 1;
            end else if (r0v) e0 = 1;
            else if (r1v) e1 = 1;
        end
        chk("ready0", REQ0_READY, e0);
        chk("ready1", REQ1_READY, e1);
        chk("clr_busy", CLR_BUSY, m_busy);
        chk("ram_en", RAM_EN, e0 | e1 | m_busy);
        if (m_busy) chk("clr_addr", RAM_ADDR, m_ci);
        if (CLR_BUSY) busy_cycles++;
        if (e0) grants.push_back(0);
        if (e1) grants.push_back(1);
        @(posedge CLK); #1;
        CLR_START = 1'b0;
        exp_rv = 0; exp_rid = 0; exp_rd = '0; exp_done = 0;
        if (m_busy) begin
            m_mem[m_ci] = CLR_VAL;
            m_ci++;
            if (m_ci == DEPTH) begin m_busy = 0; exp_done = 1; end
        end else if (cs) begin
            m_busy = 1; m_ci = 0;
        end
        if (e0) begin
            m_last = 0; g0++; r0v = 0;
            if (r0we) m_mem[r0a] = r0d;
            else begin exp_rv = 1; exp_rid = 0; exp_rd = m_mem[r0a]; end
        end
        if (e1) begin
            m_last = 1; g1++; r1v = 0;
            if (r1we) m_mem[r1a] = r1d;
            else begin exp_rv = 1; exp_rid = 1; exp_rd = m_mem[r1a]; end
        end
        chk("rvalid", RVALID, exp_rv);
        if (exp_rv) begin
            chk("rid", RID, exp_rid);
            chk("rdata", RDATA, exp_rd);
        end
        chk("clr_done", CLR_DONE, exp_done);
        if (CLR_DONE) done_cnt++;
`ifdef RAMB_ARB_STATS_EN
        chk("gnt_cnt0", GNT_CNT0, g0);
        chk("gnt_cnt1", GNT_CNT1, g1);
`endif
    endtask

    task automatic rd0(input int addr, input logic [DW-1:0] exp, input string tag);
        int n = 0;
        r0v = 1; r0we = 0; r0a = AW'(addr);
        while (r0v && n < 20) begin cycle(0); n++; end
        chk({tag, "_granted"}, r0v, 0);
        chk(tag, RDATA, exp);
    endtask

    task automatic drain();
        int n = 0;
        while ((r0v || r1v) && n < 2000) begin cycle(0); n++; end
        chk("drain", r0v | r1v, 0);
    endtask

    initial begin
        int n0, n1, n;
        for (int i = 0; i < DEPTH; i++) begin
            ram[i]   = '0;
            m_mem[i] = '0;
        end
        @(posedge CLK); #1;
        do_reset();

        // write then read back through requester 0
        r0v = 1; r0we = 1; r0a = 10'd5; r0d = 4'hA;
        cycle(0);
        r0v = 1; r0we = 0; r0a = 10'd5;
        cycle(0);
        chk("wr_rd_rvalid", RVALID, 1);
        chk("wr_rd_rid", RID, 0);
        chk("wr_rd_rdata", RDATA, 4'hA);

        // both valid for 6 cycles from a fresh pointer: 0,1,0,1,0,1
        do_reset();
        grants.delete();
        for (int i = 0; i < 6; i++) begin
            if (!r0v) begin r0v = 1; r0we = 0; r0a = AW'($urandom); end
            if (!r1v) begin r1v = 1; r1we = 0; r1a = AW'($urandom); end
            cycle(0);
        end
        for (int i = 0; i < 6; i++) chk("alt_grant", grants[i], i % 2);
        drain();

        // REQ1 alone three times, then REQ0 wins the tie
        grants.delete();
        for (int i = 0; i < 3; i++) begin
            r1v = 1; r1we = 0; r1a = AW'(i);
            cycle(0);
        end
        r0v = 1; r0we = 0; r0a = 10'd5;
        r1v = 1; r1we = 0; r1a = 10'd6;
        cycle(0);
        chk("solo_tie_len", grants.size(), 4);
        for (int i = 0; i < 3; i++) chk("solo_grant", grants[i], 1);
        chk("tie_after_solo", grants[3], 0);
        drain();

        // preload whole RAM with F, splitting even/odd addresses
        n0 = 0; n1 = 0; n = 0;
        while ((n0 < DEPTH / 2 || n1 < DEPTH / 2 || r0v || r1v) && n < 2100) begin
            if (!r0v && n0 < DEPTH / 2) begin r0v = 1; r0we = 1; r0a = AW'(2 * n0); r0d = 4'hF; n0++; end
            if (!r1v && n1 < DEPTH / 2) begin r1v = 1; r1we = 1; r1a = AW'(2 * n1 + 1); r1d = 4'hF; n1++; end
            cycle(0);
            n++;
        end
        chk("preload_done", n < 2100, 1);

        // clear started alongside two pending reads; second start mid-sweep
        r0v = 1; r0we = 0; r0a = 10'd7;
        r1v = 1; r1we = 0; r1a = 10'd9;
        busy_cycles = 0; done_cnt = 0;
        grants.delete();
        cycle(1);
        chk("start_no_grant", grants.size(), 0);
        n = 0;
        while (m_busy && n < 1100) begin cycle(n == 500); n++; end
        chk("sweep_len", n, DEPTH);
        chk("busy_cycles", busy_cycles, DEPTH);
        chk("done_pulses", done_cnt, 1);
        chk("held_during_clear", grants.size(), 0);
        drain();
        rd0(0, CLR_VAL, "clr_a0");
        rd0(511, CLR_VAL, "clr_a511");
        rd0(1023, CLR_VAL, "clr_a1023");

        // random traffic
        for (int i = 0; i < 300; i++) begin
            if (!r0v && $urandom_range(1, 0) == 1) begin
                r0v = 1; r0we = 1'($urandom); r0a = AW'($urandom); r0d = DW'($urandom);
            end
            if (!r1v && $urandom_range(1, 0) == 1) begin
                r1v = 1; r1we = 1'($urandom); r1a = AW'($urandom); r1d = DW'($urandom);
            end
            cycle(0);
        end
        drain();

        // reset in the middle of a sweep
        for (int i = 0; i < 256; i++) begin
            r0v = 1; r0we = 1; r0a = AW'(i); r0d = 4'hF;
            cycle(0);
        end
        done_cnt = 0;
        cycle(1);
        repeat (100) cycle(0);
        do_reset();
        repeat (5) cycle(0);
        chk("abort_no_done", done_cnt, 0);
        rd0(50, CLR_VAL, "abort_a50");
        rd0(200, 4'hF, "abort_a200");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
